// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
// Holds the fetch FSM encodings, the special instruction words and the reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_word_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear beats hold, hold beats load, otherwise a bubble is inserted.
// Payload fields survive a bubble; only the valid flag drops.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_hold,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;

    // Register update with clear > hold > load > bubble priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc       <= 32'h0000_0000;
            r_pc_plus4 <= 32'h0000_0000;
        end else if (i_clear) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc       <= 32'h0000_0000;
            r_pc_plus4 <= 32'h0000_0000;
        end else if (i_hold) begin
            r_valid    <= r_valid;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc + 32'd4;
        end else begin
            r_valid    <= 1'b0;
        end
    end

    // Decode sees a nop whenever the slot is empty, even though the payload is retained.
    assign o_valid    = r_valid;
    assign o_instr    = r_valid ? r_instr : NOP_INSTR;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, fetch FSM, one-entry stall buffer and instruction memory handshake.
// Redirect from EX overrides stall, returned data and halt in the same cycle.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
    parameter logic [31:0] HALT_INSTR = mips_pkg::HALT_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [5:0]  ifid_opcode,
    output logic [5:0]  ifid_funct,
    output logic        halted
);

    fetch_state_e r_state;
    fetch_state_e w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    fetch_word_t  r_buf;
    logic         w_buf_capture;
    logic         w_clear;
    logic         w_hold;
    logic         w_load;
    fetch_word_t  w_load_word;

    // State, PC and stall buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= word_align(RESET_PC);
            r_buf   <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            if (redirect) begin
                r_buf <= '0;
            end else if (w_buf_capture) begin
                r_buf <= '{instr: imem_rdata, pc: r_pc};
            end else begin
                r_buf <= r_buf;
            end
        end
    end

    // Next-state, PC and IF/ID control decode.
    always_comb begin
        w_next_state  = r_state;
        w_pc_next     = r_pc;
        w_buf_capture = 1'b0;
        w_clear       = 1'b0;
        w_hold        = 1'b0;
        w_load        = 1'b0;
        w_load_word   = r_buf;
        if (redirect) begin
            w_clear      = 1'b1;
            w_pc_next    = word_align(redirect_pc);
            w_next_state = S_FETCH;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_hold       = stall;
                    w_next_state = S_FETCH;
                end
                S_FETCH: begin
                    if (imem_rvalid && stall) begin
                        w_hold        = 1'b1;
                        w_buf_capture = 1'b1;
                        w_next_state  = S_HOLD;
                    end else if (imem_rvalid) begin
                        w_load       = 1'b1;
                        w_load_word  = '{instr: imem_rdata, pc: r_pc};
                        w_pc_next    = r_pc + 32'd4;
                        w_next_state = (imem_rdata == HALT_INSTR) ? S_HALT : S_FETCH;
                    end else begin
                        w_hold = stall;
                    end
                end
                S_HOLD: begin
                    if (stall) begin
                        w_hold = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_pc_next    = r_pc + 32'd4;
                        w_next_state = (r_buf.instr == HALT_INSTR) ? S_HALT : S_FETCH;
                    end
                end
                S_HALT: begin
                    w_hold = stall;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_hold     (w_hold),
        .i_load     (w_load),
        .i_instr    (w_load_word.instr),
        .i_pc       (w_load_word.pc),
        .o_valid    (ifid_valid),
        .o_instr    (ifid_instr),
        .o_pc       (ifid_pc),
        .o_pc_plus4 (ifid_pc_plus4)
    );

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign halted      = (r_state == S_HALT);
    assign ifid_opcode = ifid_instr[31:26];
    assign ifid_funct  = ifid_instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-programmable memory model feeds the DUT,
// directed phases push expected IF/ID entries, and a monitor pops and compares them.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [5:0]  ifid_opcode;
    logic [5:0]  ifid_funct;
    logic        halted;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        mem_en   = 1'b0;
    int          mem_lat  = 1;
    logic [31:0] halt_addr = 32'hFFFF_FFF0;
    logic        stall_q;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_opcode   (ifid_opcode),
        .ifid_funct    (ifid_funct),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a == halt_addr) return 32'hFFFF_FFFF;
        return {a[7:2], 20'hA5C3E, a[7:2]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = word_of(pc);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Memory model: answers on the mem_lat-th cycle an address has been requested.
    initial begin
        int          cnt;
        logic [31:0] cur;
        cnt = 0;
        cur = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (!mem_en || !imem_req || reset) begin
                cnt = 0;
            end else if (imem_addr != cur) begin
                cnt = 1;
            end else begin
                cnt = cnt + 1;
            end
            cur = imem_addr;
            imem_rvalid = mem_en && imem_req && !reset && (cnt >= mem_lat);
            imem_rdata  = word_of(imem_addr);
            if (imem_rvalid) cnt = 0;
        end
    end

    always @(posedge clk) stall_q <= stall;

    // Monitor: every freshly loaded IF/ID entry must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifid_valid === 1'b1 && stall_q === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ifid actual_pc=%h actual_instr=%h required=none", ifid_pc, ifid_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("ifid_instr", ifid_instr, e.instr);
                    check("ifid_pc", ifid_pc, e.pc);
                    check("ifid_pc_plus4", ifid_pc_plus4, e.pc + 32'd4);
                    check("ifid_opcode", {26'd0, ifid_opcode}, {26'd0, e.instr[31:26]});
                    check("ifid_funct", {26'd0, ifid_funct}, {26'd0, e.instr[5:0]});
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) step();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_instr", ifid_instr, 32'h0);
        check("rst_pc", ifid_pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        // Sequential single-cycle fetch from RESET_PC.
        for (int i = 0; i < 4; i++) expect_word(32'(i * 4));
        mem_en = 1'b1;
        mem_lat = 1;
        reset = 1'b0;
        step();
        check("seq_req", {31'd0, imem_req}, 32'd1);
        check("seq_addr", imem_addr, 32'h0);
        check("seq_valid0", {31'd0, ifid_valid}, 32'd0);
        repeat (4) step();
        mem_en = 1'b0;
        step();
        check("seq_bubble", {31'd0, ifid_valid}, 32'd0);
        check("seq_addr_next", imem_addr, 32'h10);

        // Three-cycle memory latency after a redirect to 0x100.
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        mem_en = 1'b1;
        mem_lat = 3;
        expect_word(32'h100);
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("lat_addr", imem_addr, 32'h100);
            check("lat_req", {31'd0, imem_req}, 32'd1);
            check("lat_valid", {31'd0, ifid_valid}, 32'd0);
            step();
        end

        // Stall while the next word returns: buffered, no refetch.
        mem_lat = 1;
        stall = 1'b1;
        expect_word(32'h104);
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_req", {31'd0, imem_req}, 32'd0);
            check("hold_ifid_pc", ifid_pc, 32'h100);
            check("hold_valid", {31'd0, ifid_valid}, 32'd1);
        end
        stall = 1'b0;
        step();
        check("hold_next_addr", imem_addr, 32'h108);
        check("hold_next_req", {31'd0, imem_req}, 32'd1);

        // Redirect beats stall and rvalid in the same cycle.
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0043;
        step();
        check("redir_valid", {31'd0, ifid_valid}, 32'd0);
        check("redir_instr", ifid_instr, 32'h0);
        check("redir_addr", imem_addr, 32'h40);
        check("redir_req", {31'd0, imem_req}, 32'd1);
        redirect = 1'b0;
        stall = 1'b0;
        mem_en = 1'b0;
        step();
        check("redir_valid2", {31'd0, ifid_valid}, 32'd0);

        // Halt word at 0x10, then resume by redirect to 0.
        halt_addr = 32'h10;
        redirect = 1'b1;
        redirect_pc = 32'h0;
        mem_en = 1'b1;
        for (int i = 0; i < 5; i++) expect_word(32'(i * 4));
        step();
        redirect = 1'b0;
        repeat (5) step();
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_req", {31'd0, imem_req}, 32'd0);
        check("halt_instr", ifid_instr, 32'hFFFF_FFFF);
        step();
        check("halt_consumed", {31'd0, ifid_valid}, 32'd0);
        check("halt_halted2", {31'd0, halted}, 32'd1);
        step();
        check("halt_req2", {31'd0, imem_req}, 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h0;
        step();
        redirect = 1'b0;
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_req", {31'd0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'h0);
        expect_word(32'h0);
        step();
        mem_en = 1'b0;
        step();
        check("pend_req", {31'd0, imem_req}, 32'd1);
        check("pend_addr", imem_addr, 32'h4);

        // Reset pulse during a pending fetch.
        reset = 1'b1;
        #2;
        check("rstpend_req", {31'd0, imem_req}, 32'd0);
        check("rstpend_addr", imem_addr, 32'h0);
        check("rstpend_valid", {31'd0, ifid_valid}, 32'd0);
        step();
        check("rstpend_req2", {31'd0, imem_req}, 32'd0);
        step();
        reset = 1'b0;
        mem_en = 1'b1;
        halt_addr = 32'hFFFF_FFF0;
        expect_word(32'h0);
        check("rel_idle_req", {31'd0, imem_req}, 32'd0);
        step();
        check("rel_req", {31'd0, imem_req}, 32'd1);
        check("rel_addr", imem_addr, 32'h0);
        check("rel_valid", {31'd0, ifid_valid}, 32'd0);
        step();
        mem_en = 1'b0;
        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
